// File: rtl/divider_pkg.sv
// Shared definitions for the iterative 32-bit divider: op codes, FSM states,
// widths and the fixed results of the two special cases.
package divider_pkg;

    localparam int DATA_W   = 32;
    localparam int ITER_CNT = 32;
    localparam int CNT_W    = $clog2(ITER_CNT);

    localparam logic [DATA_W-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;
    localparam logic [DATA_W-1:0] OVF_QUO      = 32'h8000_0000;
    localparam logic [DATA_W-1:0] OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [DATA_W-1:0] NEG_ONE      = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Absolute value of a two's-complement operand when the op is signed;
    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic              is_signed);
        return (is_signed && v[DATA_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring shift-subtract step. The quotient register
// initially holds the dividend magnitude; each step shifts its MSB into the
// partial remainder and shifts the new quotient bit into its LSB.
module divider_step
    import divider_pkg::*;
(
    input  logic [DATA_W-1:0] rem_in,
    input  logic [DATA_W-1:0] quo_in,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic [DATA_W-1:0] quo_out
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    // Trial subtraction; the borrow bit decides whether to restore.
    always_comb begin
        shifted = {rem_in, quo_in[DATA_W-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[DATA_W]) begin
            rem_out = trial[DATA_W-1:0];
            quo_out = {quo_in[DATA_W-2:0], 1'b1};
        end else begin
            rem_out = shifted[DATA_W-1:0];
            quo_out = {quo_in[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider_sequencer.sv
// Multi-cycle divide/remainder unit for the execution stage. Latches the
// instruction, runs 32 restoring steps (or short-circuits the special cases)
// and presents the signed-corrected result until the pipeline takes it.
module divider_sequencer
    import divider_pkg::*;
#(
    parameter logic HIGH = 1'b1
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [1:0]        OP,
    input  logic [DATA_W-1:0] DIVIDEND,
    input  logic [DATA_W-1:0] DIVISOR,
    input  logic              CLEAR_EXECUTION_STAGE,
    input  logic              HOLD,
    output logic [DATA_W-1:0] RESULT,
    output logic              RESULT_VALID,
    output logic              BUSY,
    output logic              STALL_EXECUTION_STAGE
);

    logic start_act;
    logic clear_act;
    logic hold_act;

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    op_e               op_q;
    logic [DATA_W-1:0] divisor_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] result_q;
    logic              neg_quo_q;
    logic              neg_rem_q;

    logic              latch_en;
    logic              step_en;
    logic              last_step;
    logic              op_signed;
    logic              op_is_rem;
    logic              is_rem_q;
    logic              div_zero;
    logic              sgn_ovf;
    logic              special;
    logic [DATA_W-1:0] rem_nxt;
    logic [DATA_W-1:0] quo_nxt;

    // Conditional two's-complement negation applied when entering DONE.
    function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                     input logic              neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign start_act = (START == HIGH);
    assign clear_act = (CLEAR_EXECUTION_STAGE == HIGH);
    assign hold_act  = (HOLD == HIGH);

    assign op_signed = (OP == OP_DIV) || (OP == OP_REM);
    assign op_is_rem = (OP == OP_REM) || (OP == OP_REMU);
    assign is_rem_q  = (op_q == OP_REM) || (op_q == OP_REMU);
    assign div_zero  = (DIVISOR == '0);
    assign sgn_ovf   = op_signed && (DIVIDEND == OVF_DIVIDEND) && (DIVISOR == NEG_ONE);
    assign special   = div_zero || sgn_ovf;
    assign last_step = (cnt_q == CNT_W'(ITER_CNT - 1));

    divider_step u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (divisor_q),
        .rem_out (rem_nxt),
        .quo_out (quo_nxt)
    );

    // State register; reset and flush both return to IDLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and status outputs; CLEAR outranks START and HOLD.
    always_comb begin
        state_d  = state_q;
        latch_en = 1'b0;
        step_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!clear_act && start_act) begin
                    latch_en = 1'b1;
                    state_d  = special ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (clear_act) begin
                    state_d = ST_IDLE;
                end else begin
                    step_en = 1'b1;
                    if (last_step) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (clear_act || !hold_act) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        BUSY                  = (state_q == ST_BUSY) ? HIGH : ~HIGH;
        RESULT_VALID          = (state_q == ST_DONE) ? HIGH : ~HIGH;
        STALL_EXECUTION_STAGE = (((state_q == ST_IDLE) && start_act) || (state_q == ST_BUSY))
                                ? HIGH : ~HIGH;
        RESULT                = (state_q == ST_DONE) ? result_q : '0;
    end

    // Operand latch, iteration datapath and final result formation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q     <= '0;
            op_q      <= OP_DIV;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (latch_en) begin
            op_q      <= op_e'(OP);
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= magnitude(DIVIDEND, op_signed);
            divisor_q <= magnitude(DIVISOR, op_signed);
            neg_quo_q <= op_signed && (DIVIDEND[DATA_W-1] ^ DIVISOR[DATA_W-1]);
            neg_rem_q <= op_signed && DIVIDEND[DATA_W-1];
            if (div_zero) begin
                result_q <= op_is_rem ? DIVIDEND : DIV_ZERO_QUO;
            end else if (sgn_ovf) begin
                result_q <= op_is_rem ? '0 : OVF_QUO;
            end
        end else if (step_en) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= last_step ? '0 : cnt_q + 1'b1;
            if (last_step) begin
                result_q <= is_rem_q ? apply_sign(rem_nxt, neg_rem_q)
                                     : apply_sign(quo_nxt, neg_quo_q);
            end
        end
    end

endmodule

// File: tb/tb_divider_sequencer.sv
// Directed bench for divider_sequencer: hand-computed quotients/remainders,
// latency and stall windows, special cases, flush, hold and reset behaviour.
module tb_divider_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [1:0]  OP;
    logic [31:0] DIVIDEND;
    logic [31:0] DIVISOR;
    logic        CLEAR_EXECUTION_STAGE;
    logic        HOLD;
    logic [31:0] RESULT;
    logic        RESULT_VALID;
    logic        BUSY;
    logic        STALL_EXECUTION_STAGE;

    int checks = 0;
    int errors = 0;

    divider_sequencer dut (
        .CLK                   (CLK),
        .RST                   (RST),
        .START                 (START),
        .OP                    (OP),
        .DIVIDEND              (DIVIDEND),
        .DIVISOR               (DIVISOR),
        .CLEAR_EXECUTION_STAGE (CLEAR_EXECUTION_STAGE),
        .HOLD                  (HOLD),
        .RESULT                (RESULT),
        .RESULT_VALID          (RESULT_VALID),
        .BUSY                  (BUSY),
        .STALL_EXECUTION_STAGE (STALL_EXECUTION_STAGE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one instruction (caller is just after a negedge), keep START up
    // while stalled as the pipeline would, then check result, latency,
    // stall window, optional HOLD and the return to IDLE.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int exp_lat, input int hold_n);
        int lat = 0;
        int stall_cnt = 0;
        logic got = 1'b0;
        logic [31:0] res = '0;
        START = 1'b1; OP = op; DIVIDEND = a; DIVISOR = b; HOLD = 1'b0;
        #1;
        if (STALL_EXECUTION_STAGE) stall_cnt++;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge CLK); #1;
            if (RESULT_VALID) begin
                got = 1'b1; lat = i; res = RESULT;
            end else if (STALL_EXECUTION_STAGE) begin
                stall_cnt++;
            end
        end
        check({tag, " result"}, res, exp);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
        check({tag, " stall_in_done"}, 32'(STALL_EXECUTION_STAGE), 32'd0);
        if (hold_n > 0) HOLD = 1'b1;
        for (int k = 1; k <= hold_n; k++) begin
            @(negedge CLK); #1;
            if (k == hold_n) HOLD = 1'b0;
            check({tag, " hold_valid"}, 32'(RESULT_VALID), 32'd1);
            check({tag, " hold_result"}, RESULT, exp);
        end
        @(negedge CLK);
        START = 1'b0;
        #1;
        check({tag, " idle_valid"}, 32'(RESULT_VALID), 32'd0);
        check({tag, " idle_result"}, RESULT, 32'd0);
        check({tag, " idle_stall"}, 32'(STALL_EXECUTION_STAGE), 32'd0);
    endtask

    initial begin
        logic vseen;
        RST = 1'b1; START = 1'b0; OP = 2'b00; DIVIDEND = '0; DIVISOR = '0;
        CLEAR_EXECUTION_STAGE = 1'b0; HOLD = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        check("rst result", RESULT, 32'd0);
        check("rst valid", 32'(RESULT_VALID), 32'd0);
        check("rst busy", 32'(BUSY), 32'd0);
        check("rst stall", 32'(STALL_EXECUTION_STAGE), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;

        do_op("divu_100_7",   2'b01, 32'd100,        32'd7,          32'd14,         33, 0);
        do_op("div_m7_2",     2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, 0);
        do_op("rem_m7_2",     2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, 0);
        do_op("remu_big_2",   2'b11, 32'hFFFF_FFF9,  32'd2,          32'd1,          33, 0);
        do_op("div_7_m2",     2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33, 0);
        do_op("rem_7_m2",     2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          33, 0);
        do_op("divu_max_16",  2'b01, 32'hFFFF_FFFF,  32'd16,         32'h0FFF_FFFF,  33, 0);
        do_op("rem_min_3",    2'b10, 32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  33, 0);
        do_op("div_min_3",    2'b00, 32'h8000_0000,  32'd3,          32'hD555_5556,  33, 0);
        do_op("div_5_0",      2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  0);
        do_op("remu_5_0",     2'b11, 32'd5,          32'd0,          32'd5,          1,  0);
        do_op("rem_m5_0",     2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1,  0);
        do_op("div_ovf",      2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  0);
        do_op("rem_ovf",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  0);
        do_op("divu_hold",    2'b01, 32'd1000,       32'd10,         32'd100,        33, 3);

        // Flush at BUSY cycle 10, then an immediate back-to-back instruction.
        vseen = 1'b0;
        START = 1'b1; OP = 2'b01; DIVIDEND = 32'd100; DIVISOR = 32'd7;
        #1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLK);
            START = 1'b0;
            #1;
            if (RESULT_VALID) vseen = 1'b1;
        end
        check("clr busy_before", 32'(BUSY), 32'd1);
        CLEAR_EXECUTION_STAGE = 1'b1;
        @(negedge CLK);
        CLEAR_EXECUTION_STAGE = 1'b0;
        #1;
        if (RESULT_VALID) vseen = 1'b1;
        check("clr busy_after", 32'(BUSY), 32'd0);
        check("clr valid_seen", 32'(vseen), 32'd0);
        check("clr result", RESULT, 32'd0);
        do_op("after_clr", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);

        // Reset in the middle of BUSY discards the operation.
        START = 1'b1; OP = 2'b01; DIVIDEND = 32'd77; DIVISOR = 32'd7;
        @(negedge CLK);
        START = 1'b0;
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst_mid result", RESULT, 32'd0);
        check("rst_mid valid", 32'(RESULT_VALID), 32'd0);
        check("rst_mid busy", 32'(BUSY), 32'd0);
        check("rst_mid stall", 32'(STALL_EXECUTION_STAGE), 32'd0);
        vseen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK); #1;
            if (RESULT_VALID) vseen = 1'b1;
        end
        check("rst_mid never_valid", 32'(vseen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
